icache_fill: RTL
================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped lines (power of 2).
REQ-002 Parameter: WORDS, 4, 32-bit words per line (fixed at 4).
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: instr_read  input  1  CPU fetch request, held with instr_addr until instr_valid.
REQ-006 Port: instr_addr  input  32  CPU fetch byte address; bits [1:0] ignored.
REQ-007 Port: instr_out  output  32  fetched instruction, meaningful only while instr_valid=1.
REQ-008 Port: instr_valid  output  1  one-cycle pulse: instr_out holds the word for the accepted request.
REQ-009 Port: flush  input  1  invalidate all lines.
REQ-010 Port: mem_read  output  1  refill read request to instruction memory.
REQ-011 Port: mem_addr  output  32  refill word byte address.
REQ-012 Port: mem_rdata  input  32  refill data, valid when mem_ready=1.
REQ-013 Port: mem_ready  input  1  memory completes current mem_read this cycle.
REQ-014 Port: miss_cnt  output  16  count of misses since reset.

Function
REQ-015 Address split SHALL be offset=addr[3:2], index=addr[3+log2(LINES):4], tag=remaining upper bits (25 bits at LINES=8).
REQ-016 Storage SHALL be per line: valid bit, tag, 4 data words.
REQ-017 FSM states SHALL be IDLE, REFILL, RESP.
REQ-018 IDLE, instr_read=1, valid[index]=1 and tag match (hit): next cycle instr_valid=1, instr_out=stored word; state stays IDLE.
REQ-019 Hit throughput SHALL be one response per cycle; a request in the same cycle as a hit response is accepted.
REQ-020 IDLE, instr_read=1, miss: latch request address, beat=0, go REFILL, miss_cnt increments (wraps 0xFFFF->0).
REQ-021 REFILL: mem_read=1, mem_addr={tag,index,beat,2'b00}; mem_addr stable until mem_ready.
REQ-022 REFILL, mem_ready=1: write mem_rdata to word[beat]; beat increments; the 2-bit beat wraps 3->0.
REQ-023 Refill SHALL fetch beats 0,1,2,3 in order regardless of requested offset.
REQ-024 After beat 3 accepted: set valid, write tag, go RESP; mem_read=0 that next cycle.
REQ-025 RESP: instr_valid=1, instr_out=word[latched offset] of refilled line; next state IDLE.
REQ-026 Miss latency SHALL be 4 mem_ready cycles plus 2 cycles; hit latency 1 cycle.
REQ-027 instr_valid SHALL be 0 in all cycles other than REQ-018/REQ-025 responses.
REQ-028 instr_read dropped during REFILL: refill completes, line installed, RESP pulse still issued.
REQ-029 flush=1 SHALL clear all valid bits at the clock edge, in any state.
REQ-030 flush with request in IDLE: flush wins; request evaluated as miss.
REQ-031 flush during REFILL: refill continues; line installed valid at completion.
REQ-032 mem_ready while not in REFILL SHALL be ignored.
REQ-033 No write path: instruction memory read-only to this block.

Reset
REQ-034 rst=1 SHALL asynchronously force: state IDLE, all valid bits 0, beat 0, miss_cnt 0, instr_valid 0, instr_out 0, mem_read 0, mem_addr 0.
REQ-035 rst mid-refill SHALL abort refill with no line installed and no response.
REQ-036 Tag/data arrays SHALL NOT require reset.

Verification
REQ-037 Cold fetch 0x0000_0008, mem_ready every cycle -> mem_addr 0x0,0x4,0x8,0xC; instr_valid 6 cycles after request with word from 0x8; miss_cnt=1.
REQ-038 Then fetch 0x0,0x4,0xC back-to-back -> three consecutive instr_valid pulses, no mem_read, miss_cnt=1.
REQ-039 Fetch 0x0000_0080 (same index 0, different tag) then 0x0 -> two misses, miss_cnt=3, correct data each.
REQ-040 mem_ready delayed 3 cycles per beat -> mem_addr held stable, response after 18 cycles total.
REQ-041 flush pulse, then fetch 0x4 -> miss, full refill, miss_cnt increments.
REQ-042 rst asserted after beat 1 of refill -> outputs zero immediately; subsequent fetch to same address misses.

Source files
------------

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache with in-order 4-word refill.
// A miss streams the whole line from memory, installs it, then answers.
module icache_fill #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        flush,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] miss_cnt
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0] r_vld;
    logic [TW-1:0]    r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];

    logic [TW-1:0] r_ltag;
    logic [IW-1:0] r_lidx;
    logic [1:0]    r_loff;
    logic [1:0]    r_beat;
    logic [15:0]   r_miss;
    logic          r_ivalid;
    logic [31:0]   r_iout;

    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_hit;
    logic          w_take_hit;
    logic          w_take_miss;
    logic          w_beat_ok;
    logic          w_last;
    logic          w_mem_read;
    logic [31:0]   w_mem_addr;
    logic          w_unused;

    assign w_tag    = instr_addr[31 -: TW];
    assign w_idx    = instr_addr[4 +: IW];
    assign w_off    = instr_addr[3:2];
    assign w_unused = ^instr_addr[1:0];

    // A flush on the same edge invalidates the line, so the lookup misses.
    assign w_hit       = r_vld[w_idx] && (r_tag[w_idx] == w_tag) && !flush;
    assign w_take_hit  = (r_state == S_IDLE) && instr_read && w_hit;
    assign w_take_miss = (r_state == S_IDLE) && instr_read && !w_hit;
    assign w_beat_ok   = (r_state == S_REFILL) && mem_ready;
    assign w_last      = w_beat_ok && (r_beat == 2'd3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and refill bus drive.
    always_comb begin
        w_next     = r_state;
        w_mem_read = 1'b0;
        w_mem_addr = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_take_miss) w_next = S_REFILL;
            end
            S_REFILL: begin
                w_mem_read = 1'b1;
                w_mem_addr = {r_ltag, r_lidx, r_beat, 2'b00};
                if (w_last) w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Valid bits, miss bookkeeping and the registered CPU response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_ltag   <= '0;
            r_lidx   <= '0;
            r_loff   <= 2'd0;
            r_beat   <= 2'd0;
            r_miss   <= 16'd0;
            r_ivalid <= 1'b0;
            r_iout   <= 32'd0;
        end else begin
            r_ivalid <= 1'b0;
            if (flush) r_vld <= '0;
            // Completing a refill installs the line even if flushed meanwhile.
            if (w_last) r_vld[r_lidx] <= 1'b1;
            if (w_beat_ok) r_beat <= r_beat + 2'd1;
            if (w_take_hit) begin
                r_ivalid <= 1'b1;
                r_iout   <= r_data[w_idx][w_off];
            end
            if (w_take_miss) begin
                r_ltag <= w_tag;
                r_lidx <= w_idx;
                r_loff <= w_off;
                r_beat <= 2'd0;
                r_miss <= r_miss + 16'd1;
            end
            if (r_state == S_RESP) begin
                r_ivalid <= 1'b1;
                r_iout   <= r_data[r_lidx][r_loff];
            end
        end
    end

    // Tag and data arrays: written only by refill beats, never reset.
    always_ff @(posedge clk) begin
        if (w_beat_ok) begin
            r_data[r_lidx][r_beat] <= mem_rdata;
            if (r_beat == 2'd3) r_tag[r_lidx] <= r_ltag;
        end
    end

    assign instr_out   = r_iout;
    assign instr_valid = r_ivalid;
    assign mem_read    = w_mem_read;
    assign mem_addr    = w_mem_addr;
    assign miss_cnt    = r_miss;
endmodule
